// File: rtl/sum_elements_pipe.sv
// Streaming vector sum: registered adder tree (one register per layer) feeding a
// frame accumulator with saturating vector count and sticky overflow flag.
module sum_elements_pipe #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(N),
  parameter int SIGNED     = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic [CNT_WIDTH-1:0]    out_count,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int L  = $clog2(N);
  localparam int NP = 1 << L;

  function automatic logic [OUT_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] e);
    if (SIGNED != 0) return OUT_WIDTH'($signed(e));
    else             return OUT_WIDTH'(e);
  endfunction

  logic en;
  logic accept;

  // A single enable stalls the whole pipe, so nothing is dropped or duplicated.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Element 0 sits in the MSB slice; missing power-of-two slots are zero-padded.
  logic [OUT_WIDTH-1:0] elem [NP];
  for (genvar i = 0; i < NP; i++) begin : g_elem
    if (i < N) begin : g_real
      assign elem[i] = extend(in_data[(N-i)*DATA_WIDTH-1 -: DATA_WIDTH]);
    end else begin : g_pad
      assign elem[i] = '0;
    end
  end

  for (genvar s = 0; s <= L; s++) begin : g_stg
    localparam int W = NP >> s;
    logic [OUT_WIDTH-1:0] d [W];
    logic                 v;
    logic                 l;

    if (s == 0) begin : g_in
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
          l <= 1'b0;
          for (int j = 0; j < W; j++) d[j] <= '0;
        end else if (en) begin
          v <= accept;
          l <= in_last;
          for (int j = 0; j < W; j++) d[j] <= elem[j];
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
          l <= 1'b0;
          for (int j = 0; j < W; j++) d[j] <= '0;
        end else if (en) begin
          v <= g_stg[s-1].v;
          l <= g_stg[s-1].l;
          for (int j = 0; j < W; j++) d[j] <= g_stg[s-1].d[2*j] + g_stg[s-1].d[2*j+1];
        end
      end
    end
  end

  logic [OUT_WIDTH-1:0] t;
  logic                 tv;
  logic                 tl;
  assign t  = g_stg[L].d[0];
  assign tv = g_stg[L].v;
  assign tl = g_stg[L].l;

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] sum;
  logic                 carry;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sticky;
  logic                 step_ovf;
  logic                 ovf_n;

  assign {carry, sum} = {1'b0, acc} + {1'b0, t};
  // Signed overflow: operands agree in sign but the result does not.
  assign step_ovf = (SIGNED != 0)
                  ? ((acc[OUT_WIDTH-1] == t[OUT_WIDTH-1]) && (sum[OUT_WIDTH-1] != acc[OUT_WIDTH-1]))
                  : carry;
  assign ovf_n = sticky | step_ovf;
  assign cnt   = (&frame_cnt) ? frame_cnt : frame_cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      frame_cnt <= '0;
      sticky    <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= tv && tl;
      if (tv) begin
        if (tl) begin
          out_data  <= sum;
          out_count <= cnt;
          out_ovf   <= ovf_n;
          acc       <= '0;
          frame_cnt <= '0;
          sticky    <= 1'b0;
        end else begin
          acc       <= sum;
          frame_cnt <= cnt;
          sticky    <= ovf_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_elements_pipe.sv
// Bench for sum_elements_pipe: directed cases on four configurations plus a
// randomized stream checked against a frame-level arithmetic model.
module tb_sum_elements_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // A: N=4 unsigned, B: N=4 signed, C: N=3 unsigned, D: N=1 unsigned (all DW=8)
  logic [31:0] a_in_data = '0;
  logic        a_in_last = 1'b0, a_in_valid = 1'b0, a_in_ready, a_out_ovf, a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [9:0]  a_out_data;
  logic [7:0]  a_out_count;

  logic [31:0] b_in_data = '0;
  logic        b_in_last = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_ovf, b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [9:0]  b_out_data;
  logic [7:0]  b_out_count;

  logic [23:0] c_in_data = '0;
  logic        c_in_last = 1'b0, c_in_valid = 1'b0, c_in_ready, c_out_ovf, c_out_valid;
  logic        c_out_ready = 1'b1;
  logic [9:0]  c_out_data;
  logic [7:0]  c_out_count;

  logic [7:0]  d_in_data = '0;
  logic        d_in_last = 1'b0, d_in_valid = 1'b0, d_in_ready, d_out_ovf, d_out_valid;
  logic        d_out_ready = 1'b1;
  logic [7:0]  d_out_data;
  logic [7:0]  d_out_count;

  sum_elements_pipe #(.N(4), .DATA_WIDTH(8), .SIGNED(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_last(a_in_last), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_count(a_out_count), .out_ovf(a_out_ovf),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  sum_elements_pipe #(.N(4), .DATA_WIDTH(8), .SIGNED(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_last(b_in_last), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_count(b_out_count), .out_ovf(b_out_ovf),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  sum_elements_pipe #(.N(3), .DATA_WIDTH(8), .SIGNED(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_last(c_in_last), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_count(c_out_count), .out_ovf(c_out_ovf),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  sum_elements_pipe #(.N(1), .DATA_WIDTH(8), .SIGNED(0)) dut_d (
    .clk(clk), .rst(rst), .in_data(d_in_data), .in_last(d_in_last), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .out_data(d_out_data), .out_count(d_out_count), .out_ovf(d_out_ovf),
    .out_valid(d_out_valid), .out_ready(d_out_ready));

  function automatic logic valid_of(input int which);
    case (which)
      0: return a_out_valid;
      1: return b_out_valid;
      2: return c_out_valid;
      default: return d_out_valid;
    endcase
  endfunction

  // Present one vector to the selected DUT for one accept edge.
  task automatic send(input int which, input logic [31:0] d, input logic last);
    @(negedge clk);
    case (which)
      0: begin a_in_data = d; a_in_last = last; a_in_valid = 1'b1; end
      1: begin b_in_data = d; b_in_last = last; b_in_valid = 1'b1; end
      2: begin c_in_data = d[23:0]; c_in_last = last; c_in_valid = 1'b1; end
      default: begin d_in_data = d[7:0]; d_in_last = last; d_in_valid = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0; d_in_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until out_valid rises; -1 on timeout.
  task automatic wait_out(input int which, output int edges);
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (valid_of(which)) begin
        edges = k;
        return;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 10'd0 || a_out_count !== 8'd0 || a_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%0d c=%0d o=%b, want all 0",
               a_out_valid, a_out_data, a_out_count, a_out_ovf);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latency;
    int e;
    send(0, {8'd1, 8'd2, 8'd3, 8'd4}, 1'b1);
    wait_out(0, e);
    checks++;
    if (e !== 3) begin failures++; $display("FAIL latency_n4: got %0d edges want 3", e); end
    checks++;
    if (a_out_data !== 10'd10 || a_out_count !== 8'd1 || a_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL sum_1234: got d=%0d c=%0d o=%b want d=10 c=1 o=0", a_out_data, a_out_count, a_out_ovf);
    end
  endtask

  task automatic test_overflow;
    int e;
    send(0, 32'hFFFF_FFFF, 1'b0);
    send(0, 32'hFFFF_FFFF, 1'b0);
    send(0, 32'hFFFF_FFFF, 1'b1);
    wait_out(0, e);
    checks++;
    if (e < 0 || a_out_data !== 10'd1012 || a_out_count !== 8'd3 || a_out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_frame: got e=%0d d=%0d c=%0d o=%b want d=1012 c=3 o=1",
               e, a_out_data, a_out_count, a_out_ovf);
    end
    send(0, 32'h0101_0101, 1'b1);
    wait_out(0, e);
    checks++;
    if (e < 0 || a_out_data !== 10'd4 || a_out_count !== 8'd1 || a_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL after_ovf_clean: got e=%0d d=%0d c=%0d o=%b want d=4 c=1 o=0",
               e, a_out_data, a_out_count, a_out_ovf);
    end
  endtask

  task automatic test_signed;
    int e;
    send(1, {8'hFF, 8'hFE, 8'h03, 8'hFC}, 1'b1);
    wait_out(1, e);
    checks++;
    if (e !== 3 || b_out_data !== 10'h3FC || b_out_count !== 8'd1 || b_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL signed_neg: got e=%0d d=%h c=%0d o=%b want e=3 d=3fc c=1 o=0",
               e, b_out_data, b_out_count, b_out_ovf);
    end
    send(1, 32'h7F7F_7F7F, 1'b0);
    send(1, 32'h7F7F_7F7F, 1'b1);
    wait_out(1, e);
    checks++;
    if (e < 0 || b_out_data !== 10'h3F8 || b_out_count !== 8'd2 || b_out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL signed_ovf: got e=%0d d=%h c=%0d o=%b want d=3f8 c=2 o=1",
               e, b_out_data, b_out_count, b_out_ovf);
    end
  endtask

  task automatic test_odd_n;
    int e;
    send(2, {8'd0, 8'd5, 8'd6, 8'd7}, 1'b1);
    wait_out(2, e);
    checks++;
    if (e !== 3 || c_out_data !== 10'd18 || c_out_count !== 8'd1) begin
      failures++;
      $display("FAIL n3_sum: got e=%0d d=%0d c=%0d want e=3 d=18 c=1", e, c_out_data, c_out_count);
    end
    send(3, 32'd9, 1'b1);
    wait_out(3, e);
    checks++;
    if (e !== 1 || d_out_data !== 8'd9 || d_out_count !== 8'd1) begin
      failures++;
      $display("FAIL n1_sum: got e=%0d d=%0d c=%0d want e=1 d=9 c=1", e, d_out_data, d_out_count);
    end
  endtask

  task automatic test_backpressure;
    int nxt_in = 1, nxt_out = 1;
    logic        stalled = 1'b0;
    logic [9:0]  held = '0;
    logic [7:0]  b;
    for (int cyc = 0; cyc < 80 && nxt_out <= 10; cyc++) begin
      @(negedge clk);
      a_out_ready = !(cyc >= 6 && cyc < 11);
      a_in_valid  = (nxt_in <= 10);
      b           = 8'(nxt_in);
      a_in_data   = {b, 24'd0};
      a_in_last   = 1'b1;
      #1;
      checks++;
      if (a_in_ready !== !(a_out_valid && !a_out_ready)) begin
        failures++;
        $display("FAIL bp_in_ready: got %b with out_valid=%b out_ready=%b", a_in_ready, a_out_valid, a_out_ready);
      end
      if (stalled) begin
        checks++;
        if (!a_out_valid || a_out_data !== held) begin
          failures++;
          $display("FAIL bp_stable: got v=%b d=%0d want v=1 d=%0d", a_out_valid, a_out_data, held);
        end
      end
      stalled = a_out_valid && !a_out_ready;
      held    = a_out_data;
      if (a_in_valid && a_in_ready) nxt_in++;
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_data !== 10'(nxt_out) || a_out_count !== 8'd1) begin
          failures++;
          $display("FAIL bp_order: got d=%0d c=%0d want d=%0d c=1", a_out_data, a_out_count, nxt_out);
        end
        nxt_out++;
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    checks++;
    if (nxt_out !== 11) begin
      failures++;
      $display("FAIL bp_count: got %0d results want 10", nxt_out - 1);
    end
  endtask

  typedef struct {
    logic [9:0] d;
    logic [7:0] c;
    logic       o;
  } exp_t;

  task automatic test_random;
    exp_t q[$];
    exp_t x;
    int   fsum = 0, fvec = 0, s;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      a_in_last   = ($urandom_range(0, 2) == 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (a_in_ready !== (!a_out_valid || a_out_ready)) begin
        failures++;
        $display("FAIL rnd_in_ready: got %b", a_in_ready);
      end
      if (a_in_valid && a_in_ready) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(a_in_data[8*k +: 8]);
        fsum += s;
        fvec++;
        if (a_in_last) begin
          x.d = 10'(fsum % 1024);
          x.c = 8'((fvec > 255) ? 255 : fvec);
          x.o = (fsum > 1023);
          q.push_back(x);
          fsum = 0;
          fvec = 0;
        end
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra: unexpected result d=%0d", a_out_data);
        end else begin
          x = q.pop_front();
          if (a_out_data !== x.d || a_out_count !== x.c || a_out_ovf !== x.o) begin
            failures++;
            $display("FAIL rnd_result: got d=%0d c=%0d o=%b want d=%0d c=%0d o=%b",
                     a_out_data, a_out_count, a_out_ovf, x.d, x.c, x.o);
          end
        end
      end
    end
    // Close any open frame, then drain.
    if (fvec != 0) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_last = 1'b1; a_in_data = '0; a_out_ready = 1'b1;
      x.d = 10'(fsum % 1024);
      x.c = 8'((fvec + 1 > 255) ? 255 : fvec + 1);
      x.o = (fsum > 1023);
      #1;
      if (a_out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra: unexpected result d=%0d", a_out_data);
        end else begin
          exp_t y;
          y = q.pop_front();
          if (a_out_data !== y.d || a_out_count !== y.c || a_out_ovf !== y.o) begin
            failures++;
            $display("FAIL rnd_result: got d=%0d c=%0d o=%b want d=%0d c=%0d o=%b",
                     a_out_data, a_out_count, a_out_ovf, y.d, y.c, y.o);
          end
        end
      end
      q.push_back(x);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      #1;
      if (a_out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra: unexpected result d=%0d", a_out_data);
        end else begin
          x = q.pop_front();
          if (a_out_data !== x.d || a_out_count !== x.c || a_out_ovf !== x.o) begin
            failures++;
            $display("FAIL rnd_result: got d=%0d c=%0d o=%b want d=%0d c=%0d o=%b",
                     a_out_data, a_out_count, a_out_ovf, x.d, x.c, x.o);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_lost: got %0d results missing want 0", q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int e;
    send(0, 32'h1111_1111, 1'b0);
    send(0, 32'h2222_2222, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 10'd0 || a_out_count !== 8'd0 || a_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got v=%b d=%0d c=%0d o=%b want all 0",
               a_out_valid, a_out_data, a_out_count, a_out_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    send(0, {8'd1, 8'd2, 8'd3, 8'd4}, 1'b1);
    wait_out(0, e);
    checks++;
    if (e !== 3 || a_out_data !== 10'd10 || a_out_count !== 8'd1 || a_out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_frame: got e=%0d d=%0d c=%0d o=%b want e=3 d=10 c=1 o=0",
               e, a_out_data, a_out_count, a_out_ovf);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_overflow;
    test_signed;
    test_odd_n;
    test_backpressure;
    test_random;
    test_reset_mid_frame;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
